chip8_fb_arbiter: RTL and testbench

//  Shares the single-port 2048x1 Chip8 framebuffer RAM between the VGA scan-out read port and the Chip8 CPU.
//  - VGA side: pixel address in, pixel bit out.
//  - CPU side: READ, WRITE, XOR (sprite draw with collision) and CLEAR_ALL ops, using a req/ack handshake.
//  - Fixed TDM slots give VGA a guaranteed read every 2 clk50 cycles; the CPU gets the other slot.
//  - Sits between the CPU draw logic and the framebuffer RAM, and feeds the VGA emulator's fb_pixel_data.

---
 rtl/chip8_fb_pkg.sv | 24 ++
 rtl/chip8_fb_arbiter.sv | 179 +++++++++++++++++
 tb/tb_chip8_fb_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_fb_pkg.sv
// rtl/chip8_fb_pkg.sv - shared types and sizes for the Chip8 framebuffer arbiter
package chip8_fb_pkg;

    localparam int FB_ADDR_W = 11;
    localparam int FB_DEPTH  = 2048;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_XOR   = 2'd2,
        OP_CLEAR = 2'd3
    } fb_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_CAP,
        ST_XOR_WR,
        ST_CLEAR,
        ST_ACK
    } fb_state_t;

endpackage

// File: rtl/chip8_fb_arbiter.sv
// rtl/chip8_fb_arbiter.sv - TDM arbiter sharing the 2048x1 framebuffer RAM between VGA scan-out and the CPU
// FB_CLEAR_EN enables the hardware CLEAR sweep; without it CLEAR is acked immediately with no RAM writes.
module chip8_fb_arbiter
    import chip8_fb_pkg::*;
(
    input  logic                 clk50,
    input  logic                 reset,
    input  logic [FB_ADDR_W-1:0] vga_addr,
    output logic                 vga_pixel,
    input  logic                 cpu_req,
    input  logic [1:0]           cpu_op,
    input  logic [FB_ADDR_W-1:0] cpu_addr,
    input  logic                 cpu_wdata,
    output logic                 cpu_busy,
    output logic                 cpu_ack,
    output logic                 cpu_rdata,
    output logic                 cpu_collision,
    output logic [FB_ADDR_W-1:0] ram_addr,
    output logic                 ram_we,
    output logic                 ram_wdata,
    input  logic                 ram_rdata
);

    logic                 r_slot;
    fb_state_t            r_state;
    fb_op_t               r_op;
    logic [FB_ADDR_W-1:0] r_addr;
    logic                 r_wdata;
    logic                 r_old;
    logic                 r_busy;
    logic                 r_ack;
    logic                 r_rdata;
    logic                 r_collision;
    logic                 r_vga_pixel;
`ifdef FB_CLEAR_EN
    logic [FB_ADDR_W-1:0] r_clr_addr;
`endif

    logic [FB_ADDR_W-1:0] w_cpu_addr;
    logic                 w_cpu_we;
    logic                 w_cpu_wdata;

    always_ff @(posedge clk50 or posedge reset) begin
        if (reset) begin
            r_slot      <= 1'b0;
            r_state     <= ST_IDLE;
            r_op        <= OP_READ;
            r_addr      <= '0;
            r_wdata     <= 1'b0;
            r_old       <= 1'b0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_rdata     <= 1'b0;
            r_collision <= 1'b0;
            r_vga_pixel <= 1'b0;
`ifdef FB_CLEAR_EN
            r_clr_addr  <= '0;
`endif
        end else begin
            r_slot <= ~r_slot;
            r_ack  <= 1'b0;
            // ram_rdata in a slot=1 cycle answers the VGA address issued in the preceding slot=0 cycle
            if (r_slot)
                r_vga_pixel <= ram_rdata;

            case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        r_op    <= fb_op_t'(cpu_op);
                        r_addr  <= cpu_addr;
                        r_wdata <= cpu_wdata;
                        r_busy  <= 1'b1;
                        case (fb_op_t'(cpu_op))
                            OP_WRITE:        r_state <= ST_WR;
                            OP_READ, OP_XOR: r_state <= ST_RD_ISSUE;
                            default: begin
`ifdef FB_CLEAR_EN
                                r_state <= ST_CLEAR;
`else
                                r_state     <= ST_ACK;
                                r_ack       <= 1'b1;
                                r_rdata     <= 1'b0;
                                r_collision <= 1'b0;
`endif
                            end
                        endcase
                    end
                end
                ST_WR: begin
                    if (r_slot) begin
                        r_state     <= ST_ACK;
                        r_ack       <= 1'b1;
                        r_rdata     <= 1'b0;
                        r_collision <= 1'b0;
                    end
                end
                ST_RD_ISSUE: begin
                    if (r_slot)
                        r_state <= ST_RD_CAP;
                end
                ST_RD_CAP: begin
                    if (!r_slot) begin
                        r_old <= ram_rdata;
                        if (r_op == OP_XOR) begin
                            r_state <= ST_XOR_WR;
                        end else begin
                            r_state     <= ST_ACK;
                            r_ack       <= 1'b1;
                            r_rdata     <= ram_rdata;
                            r_collision <= 1'b0;
                        end
                    end
                end
                ST_XOR_WR: begin
                    if (r_slot) begin
                        r_state     <= ST_ACK;
                        r_ack       <= 1'b1;
                        r_rdata     <= r_old;
                        r_collision <= r_old & r_wdata;
                    end
                end
`ifdef FB_CLEAR_EN
                ST_CLEAR: begin
                    if (r_slot) begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                        if (r_clr_addr == FB_ADDR_W'(FB_DEPTH - 1)) begin
                            r_state     <= ST_ACK;
                            r_ack       <= 1'b1;
                            r_rdata     <= 1'b0;
                            r_collision <= 1'b0;
                        end
                    end
                end
`endif
                ST_ACK: begin
                    r_busy      <= 1'b0;
                    r_rdata     <= 1'b0;
                    r_collision <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // CPU-side RAM request is only ever let through in the slot=1 half
    always_comb begin
        w_cpu_addr  = r_addr;
        w_cpu_we    = 1'b0;
        w_cpu_wdata = 1'b0;
        case (r_state)
            ST_WR: begin
                w_cpu_we    = 1'b1;
                w_cpu_wdata = r_wdata;
            end
            ST_XOR_WR: begin
                w_cpu_we    = 1'b1;
                w_cpu_wdata = r_old ^ r_wdata;
            end
`ifdef FB_CLEAR_EN
            ST_CLEAR: begin
                w_cpu_addr = r_clr_addr;
                w_cpu_we   = 1'b1;
            end
`endif
            default: ;
        endcase
        ram_addr  = r_slot ? w_cpu_addr : vga_addr;
        ram_we    = r_slot & w_cpu_we;
        ram_wdata = r_slot & w_cpu_wdata;
    end

    assign vga_pixel     = r_vga_pixel;
    assign cpu_busy      = r_busy;
    assign cpu_ack       = r_ack;
    assign cpu_rdata     = r_rdata;
    assign cpu_collision = r_collision;

endmodule

// File: tb/tb_chip8_fb_arbiter.sv
// tb/tb_chip8_fb_arbiter.sv - directed self-checking bench for chip8_fb_arbiter
module tb_chip8_fb_arbiter;
    import chip8_fb_pkg::*;

    logic        clk50 = 1'b0;
    logic        reset;
    logic [10:0] vga_addr;
    logic        vga_pixel;
    logic        cpu_req;
    logic [1:0]  cpu_op;
    logic [10:0] cpu_addr;
    logic        cpu_wdata;
    logic        cpu_busy;
    logic        cpu_ack;
    logic        cpu_rdata;
    logic        cpu_collision;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic        ram_wdata;
    logic        ram_rdata;

    logic        mem [2048];
    logic        exp_mem [2048];
    logic        mem_load;
    logic        tb_slot;

    int n_checks = 0;
    int n_errors = 0;
    int we_slot0_err = 0;
    int route_err = 0;
    int we_cnt = 0;

`ifdef FB_CLEAR_EN
    localparam int MIX_CLR = 0;
`else
    localparam int MIX_CLR = 3;
`endif
    int mop [9] = '{1, 2, 2, 1, MIX_CLR, 2, 2, 1, 0};
    int mad [9] = '{1, 1, 2, 3, 3, 3, 4, 2, 2};
    int mwd [9] = '{1, 1, 1, 1, 0, 1, 0, 0, 0};

    chip8_fb_arbiter dut (
        .clk50         (clk50),
        .reset         (reset),
        .vga_addr      (vga_addr),
        .vga_pixel     (vga_pixel),
        .cpu_req       (cpu_req),
        .cpu_op        (cpu_op),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_busy      (cpu_busy),
        .cpu_ack       (cpu_ack),
        .cpu_rdata     (cpu_rdata),
        .cpu_collision (cpu_collision),
        .ram_addr      (ram_addr),
        .ram_we        (ram_we),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata)
    );

    always #10 clk50 = ~clk50;

    function automatic logic pat(input int i);
        logic [10:0] v;
        v = i[10:0];
        return (i < 64) ? 1'b0 : (v[0] ^ v[4]);
    endfunction

    always @(posedge clk50) begin
        if (mem_load) begin
            for (int i = 0; i < 2048; i++)
                mem[i] <= pat(i);
        end else begin
            if (ram_we)
                mem[ram_addr] <= ram_wdata;
            ram_rdata <= mem[ram_addr];
        end
    end

    always @(posedge clk50 or posedge reset) begin
        if (reset) tb_slot <= 1'b0;
        else       tb_slot <= ~tb_slot;
    end

    always begin
        @(negedge clk50);
        #1;
        if (!reset) begin
            if (!tb_slot && ram_we) we_slot0_err++;
            if (!tb_slot && ram_addr !== vga_addr) route_err++;
            if (ram_we) we_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic do_op(input logic [1:0] op, input logic [10:0] addr, input logic wd,
                         output int lat, output logic rd, output logic col);
        int busy_low;
        busy_low = 0;
        lat = 0;
        @(negedge clk50);
        cpu_req = 1'b1; cpu_op = op; cpu_addr = addr; cpu_wdata = wd;
        @(posedge clk50);
        for (int k = 1; k <= 5000; k++) begin
            @(negedge clk50);
            if (!cpu_busy) busy_low++;
            if (cpu_ack) begin
                lat = k;
                break;
            end
        end
        rd = cpu_rdata;
        col = cpu_collision;
        cpu_req = 1'b0;
        if (lat == 0) check("ack_timeout", 0, 1);
        check("busy_held", busy_low, 0);
    endtask

    task automatic vga_expect(input string tag, input logic [10:0] a, input logic e);
        @(negedge clk50);
        vga_addr = a;
        repeat (3) @(posedge clk50);
        @(negedge clk50);
        check(tag, vga_pixel, e);
    endtask

    initial begin
        int lat;
        logic rd, col;
        int bad, w0;

        reset = 1'b1; mem_load = 1'b1; cpu_req = 1'b0; cpu_op = 2'd0;
        cpu_addr = '0; cpu_wdata = 1'b0; vga_addr = '0;
        for (int i = 0; i < 2048; i++) exp_mem[i] = pat(i);
        repeat (3) @(negedge clk50);
        check("rst_vga_pixel", vga_pixel, 0);
        check("rst_busy", cpu_busy, 0);
        check("rst_ack", cpu_ack, 0);
        check("rst_rdata", cpu_rdata, 0);
        check("rst_collision", cpu_collision, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_wdata", ram_wdata, 0);
        mem_load = 1'b0;
        reset = 1'b0;

`ifdef FB_CLEAR_EN
        do_op(OP_CLEAR, 11'd0, 1'b0, lat, rd, col);
        check("clr_lat_ok", (lat >= 4096 && lat <= 4098), 1);
        for (int i = 0; i < 2048; i++) exp_mem[i] = 1'b0;
        bad = 0;
        for (int a = 0; a < 2048; a++) begin
            @(negedge clk50);
            vga_addr = a[10:0];
            repeat (3) @(posedge clk50);
            #1;
            if (vga_pixel !== 1'b0) bad++;
        end
        check("clr_sweep_bad", bad, 0);
`endif

        do_op(OP_WRITE, 11'h7FF, 1'b1, lat, rd, col);
        check("wr_lat_ok", (lat >= 2 && lat <= 3), 1);
        exp_mem[11'h7FF] = 1'b1;
        do_op(OP_READ, 11'h7FF, 1'b0, lat, rd, col);
        check("rd_lat_ok", (lat >= 3 && lat <= 4), 1);
        check("rd_7ff_rdata", rd, 1);
        check("rd_collision", col, 0);
        vga_expect("vga_7ff", 11'h7FF, 1'b1);

        do_op(OP_XOR, 11'd5, 1'b1, lat, rd, col);
        check("xor1_lat_ok", (lat >= 4 && lat <= 6), 1);
        check("xor1_rdata", rd, 0);
        check("xor1_collision", col, 0);
        vga_expect("xor1_pixel", 11'd5, 1'b1);
        do_op(OP_XOR, 11'd5, 1'b1, lat, rd, col);
        check("xor2_rdata", rd, 1);
        check("xor2_collision", col, 1);
        vga_expect("xor2_pixel", 11'd5, 1'b0);

        fork
            begin
                for (int j = 0; j < 9; j++) begin
                    logic e_rd, e_col;
                    e_rd  = (mop[j] == 0 || mop[j] == 2) ? exp_mem[mad[j]] : 1'b0;
                    e_col = (mop[j] == 2) ? (exp_mem[mad[j]] & mwd[j][0]) : 1'b0;
                    do_op(mop[j][1:0], mad[j][10:0], mwd[j][0], lat, rd, col);
                    check("mix_rdata", rd, e_rd);
                    check("mix_collision", col, e_col);
                    if (mop[j] == 1) exp_mem[mad[j]] = mwd[j][0];
                    if (mop[j] == 2) exp_mem[mad[j]] = exp_mem[mad[j]] ^ mwd[j][0];
                end
            end
            begin
                for (int j = 0; j < 16; j++) begin
                    logic [10:0] a;
                    a = 11'($urandom_range(2047, 64));
                    vga_expect("mix_vga_pixel", a, exp_mem[a]);
                end
            end
        join
        for (int a = 1; a <= 4; a++) begin
            do_op(OP_READ, a[10:0], 1'b0, lat, rd, col);
            check("mix_final_rd", rd, exp_mem[a]);
        end

        @(negedge clk50);
        vga_addr = '0;
`ifdef FB_CLEAR_EN
        cpu_op = OP_CLEAR;
`else
        cpu_op = OP_XOR;
`endif
        cpu_req = 1'b1; cpu_addr = 11'd9; cpu_wdata = 1'b1;
        @(posedge clk50);
`ifdef FB_CLEAR_EN
        repeat (201) @(negedge clk50);
`else
        @(negedge clk50);
`endif
        reset = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk50);
        check("mid_rst_busy", cpu_busy, 0);
        check("mid_rst_ack", cpu_ack, 0);
        check("mid_rst_rdata", cpu_rdata, 0);
        check("mid_rst_coll", cpu_collision, 0);
        check("mid_rst_pixel", vga_pixel, 0);
        check("mid_rst_we", ram_we, 0);
        check("mid_rst_addr", ram_addr, 0);
        check("mid_rst_wdata", ram_wdata, 0);
        reset = 1'b0;
        do_op(OP_WRITE, 11'd10, 1'b1, lat, rd, col);
        check("post_rst_wr_lat_ok", (lat >= 2 && lat <= 3), 1);

`ifndef FB_CLEAR_EN
        exp_mem[10] = 1'b1;
        w0 = we_cnt;
        do_op(OP_CLEAR, 11'd0, 1'b0, lat, rd, col);
        check("clr_off_lat", lat, 1);
        check("clr_off_rdata", rd, 0);
        check("clr_off_coll", col, 0);
        repeat (2) @(negedge clk50);
        check("clr_off_writes", we_cnt - w0, 0);
        do_op(OP_READ, 11'h7FF, 1'b0, lat, rd, col);
        check("clr_off_keep_7ff", rd, 1);
        vga_expect("clr_off_keep_10", 11'd10, 1'b1);
        vga_expect("clr_off_keep_pat", 11'd81, exp_mem[81]);
`endif

        check("we_in_slot0", we_slot0_err, 0);
        check("vga_routing", route_err, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
